// File: rtl/ev22_pkg.sv
// Shared sequencing definitions: opcode encodings, flag bit positions and
// the jump-condition decode used by the program-counter sequencer.
package ev22_pkg;

    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZE  = 3'b010;
    localparam logic [2:0] OP_JNE  = 3'b011;
    localparam logic [2:0] OP_JCY  = 3'b100;
    localparam logic [2:0] OP_JNC  = 3'b101;
    localparam logic [2:0] OP_CALL = 3'b110;
    localparam logic [2:0] OP_RET  = 3'b111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    // True when a plain (non-stack) jump opcode is taken with the given flags.
    // CALL/RET and NEXT return 0; stack operations are decided separately.
    function automatic logic cond_met(input logic [2:0] op, input logic [2:0] flags);
        logic r;
        r = 1'b0;
        case (op)
            OP_JMP:  r = 1'b1;
            OP_JZE:  r = flags[FLAG_Z];
            OP_JNE:  r = flags[FLAG_N];
            OP_JCY:  r = flags[FLAG_C];
            OP_JNC:  r = ~flags[FLAG_C];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address stack. Holds up to STACK_DEPTH addresses; the caller
// guarantees push only when not full and pop only when not empty.
module ret_stack #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_data,
    output logic [ADDR_W-1:0] o_top,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] w_top;

    // Occupancy counter: grows on push, shrinks on pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_push) begin
            r_count <= r_count + 1'b1;
        end else if (i_pop) begin
            r_count <= r_count - 1'b1;
        end
    end

    // One register per entry; the slot at the current count receives a push.
    genvar gi;
    generate
        for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_mem[gi] <= '0;
                end else if (i_push && (r_count == CNT_W'(gi))) begin
                    r_mem[gi] <= i_push_data;
                end
            end
        end
    endgenerate

    // Top-of-stack select: entry count-1, or zero when empty.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_count == CNT_W'(i + 1)) begin
                w_top = r_mem[i];
            end
        end
    end

    assign o_top   = w_top;
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(STACK_DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: flag register, jump-condition decode, PC
// register, return-stack control and sticky stack-fault flag.
module pc_sequencer
    import ev22_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 4,
    parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [2:0]        i_opcode,
    input  logic [ADDR_W-1:0] i_target,
    input  logic              i_flag_ld,
    input  logic [DATA_W-1:0] i_w,
    input  logic              i_cy,
    input  logic              i_err_clr,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_taken,
    output logic [2:0]        o_flags,
    output logic [SP_W-1:0]   o_sp,
    output logic              o_stack_err
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_taken;
    logic [2:0]        r_flags;
    logic              r_stack_err;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_taken_next;
    logic              w_push;
    logic              w_pop;
    logic              w_fault;
    logic [ADDR_W-1:0] w_top;
    logic [SP_W-1:0]   w_count;
    logic              w_full;
    logic              w_empty;

    ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH),
        .CNT_W       (SP_W)
    ) u_ret_stack (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_inc),
        .o_top       (w_top),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Next-PC selection. Conditions use the flags held before this edge, so a
    // same-cycle flag load only affects the following instruction.
    always_comb begin
        w_pc_inc     = r_pc + 1'b1;
        w_pc_next    = w_pc_inc;
        w_taken_next = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_fault      = 1'b0;
        if (i_en) begin
            if (i_opcode == OP_CALL) begin
                if (w_full) begin
                    w_fault = 1'b1;
                end else begin
                    w_push       = 1'b1;
                    w_pc_next    = i_target;
                    w_taken_next = 1'b1;
                end
            end else if (i_opcode == OP_RET) begin
                if (w_empty) begin
                    w_fault = 1'b1;
                end else begin
                    w_pop        = 1'b1;
                    w_pc_next    = w_top;
                    w_taken_next = 1'b1;
                end
            end else if (cond_met(i_opcode, r_flags)) begin
                w_pc_next    = i_target;
                w_taken_next = 1'b1;
            end
        end
    end

    // PC and TAKEN advance only on an enabled step; TAKEN is a one-cycle pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc    <= '0;
            r_taken <= 1'b0;
        end else if (i_en) begin
            r_pc    <= w_pc_next;
            r_taken <= w_taken_next;
        end else begin
            r_taken <= 1'b0;
        end
    end

    // Flag capture from the accumulator and carry, independent of the step enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flags <= '0;
        end else if (i_flag_ld) begin
            r_flags[FLAG_Z] <= (i_w == '0);
            r_flags[FLAG_N] <= i_w[DATA_W-1];
            r_flags[FLAG_C] <= i_cy;
        end
    end

    // Sticky stack fault; a new fault beats a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stack_err <= 1'b0;
        end else if (w_fault) begin
            r_stack_err <= 1'b1;
        end else if (i_err_clr) begin
            r_stack_err <= 1'b0;
        end
    end

    assign o_pc        = r_pc;
    assign o_taken     = r_taken;
    assign o_flags     = r_flags;
    assign o_sp        = w_count;
    assign o_stack_err = r_stack_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a reference model pushes expected
// outputs per step into a queue, a monitor pops and compares after each edge,
// and scenario tasks add directed checks against fixed values.
module tb_pc_sequencer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4;
    localparam int SP_W   = $clog2(DEPTH + 1);

    localparam logic [2:0] NEXT = 3'b000, JMP = 3'b001, JZE = 3'b010, JNE = 3'b011;
    localparam logic [2:0] JCY = 3'b100, JNC = 3'b101, CALL = 3'b110, RET = 3'b111;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [2:0]        opcode = 3'b000;
    logic [ADDR_W-1:0] target = '0;
    logic              flag_ld = 1'b0;
    logic [DATA_W-1:0] w = '0;
    logic              cy = 1'b0;
    logic              err_clr = 1'b0;
    logic [ADDR_W-1:0] o_pc;
    logic              o_taken;
    logic [2:0]        o_flags;
    logic [SP_W-1:0]   o_sp;
    logic              o_stack_err;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              taken;
        logic [2:0]        flags;
        logic [SP_W-1:0]   sp;
        logic              err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state
    logic [ADDR_W-1:0] m_pc;
    logic              m_taken;
    logic [2:0]        m_flags;
    int                m_sp;
    logic [ADDR_W-1:0] m_stk [DEPTH];
    logic              m_err;

    always #5 clk = ~clk;

    pc_sequencer #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_opcode    (opcode),
        .i_target    (target),
        .i_flag_ld   (flag_ld),
        .i_w         (w),
        .i_cy        (cy),
        .i_err_clr   (err_clr),
        .o_pc        (o_pc),
        .o_taken     (o_taken),
        .o_flags     (o_flags),
        .o_sp        (o_sp),
        .o_stack_err (o_stack_err)
    );

    // Scoreboard monitor: one compare and one line per transaction.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            total++;
            if (o_pc !== mon_e.pc || o_taken !== mon_e.taken || o_flags !== mon_e.flags ||
                o_sp !== mon_e.sp || o_stack_err !== mon_e.err) begin
                bad++;
                $display("FAIL scoreboard t=%0t got pc=%h tk=%b fl=%b sp=%0d err=%b want pc=%h tk=%b fl=%b sp=%0d err=%b",
                         $time, o_pc, o_taken, o_flags, o_sp, o_stack_err,
                         mon_e.pc, mon_e.taken, mon_e.flags, mon_e.sp, mon_e.err);
            end else begin
                $display("txn t=%0t pc=%h tk=%b fl=%b sp=%0d err=%b", $time, o_pc, o_taken, o_flags, o_sp, o_stack_err);
            end
        end
    end

    task automatic model_reset();
        m_pc = '0; m_taken = 1'b0; m_flags = '0; m_sp = 0; m_err = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_stk[i] = '0;
    endtask

    // Drive one cycle, advance the model, queue the expected result.
    task automatic step(input logic e, input logic [2:0] op, input logic [ADDR_W-1:0] tgt,
                        input logic fld, input logic [DATA_W-1:0] wv, input logic c, input logic ec);
        logic [ADDR_W-1:0] npc;
        logic tk, fault;
        exp_t x;
        @(negedge clk);
        en = e; opcode = op; target = tgt; flag_ld = fld; w = wv; cy = c; err_clr = ec;
        npc = m_pc + 12'd1; tk = 1'b0; fault = 1'b0;
        if (e) begin
            case (op)
                JMP: tk = 1'b1;
                JZE: tk = m_flags[0];
                JNE: tk = m_flags[1];
                JCY: tk = m_flags[2];
                JNC: tk = !m_flags[2];
                CALL: begin
                    if (m_sp < DEPTH) begin
                        m_stk[m_sp] = m_pc + 12'd1; m_sp++; tk = 1'b1;
                    end else fault = 1'b1;
                end
                RET: begin
                    if (m_sp > 0) begin
                        m_sp--; tk = 1'b1;
                    end else fault = 1'b1;
                end
                default: tk = 1'b0;
            endcase
            if (tk) npc = (op == RET) ? m_stk[m_sp] : tgt;
            m_pc = npc;
            m_taken = tk;
        end else begin
            m_taken = 1'b0;
        end
        if (fault) m_err = 1'b1;
        else if (ec) m_err = 1'b0;
        if (fld) m_flags = {c, wv[DATA_W-1], (wv == '0)};
        x.pc = m_pc; x.taken = m_taken; x.flags = m_flags; x.sp = SP_W'(m_sp); x.err = m_err;
        exp_q.push_back(x);
        @(posedge clk);
        #2;
        en = 1'b0; flag_ld = 1'b0; err_clr = 1'b0;
    endtask

    task automatic apply_reset();
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        total++; if (o_pc !== 12'h000) begin bad++; $display("FAIL reset_pc got %h want 000", o_pc); end
        total++; if (o_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got %b want 0", o_taken); end
        total++; if (o_flags !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", o_flags); end
        total++; if (o_sp !== 3'd0) begin bad++; $display("FAIL reset_sp got %0d want 0", o_sp); end
        total++; if (o_stack_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", o_stack_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_next_wrap();
        for (int i = 0; i < 4096; i++) begin
            step(1'b1, NEXT, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0);
            if (i == 4094) begin
                total++; if (o_pc !== 12'hFFF) begin bad++; $display("FAIL wrap_top got %h want fff", o_pc); end
            end
        end
        total++; if (o_pc !== 12'h000) begin bad++; $display("FAIL wrap_zero got %h want 000", o_pc); end
        total++; if (o_taken !== 1'b0) begin bad++; $display("FAIL wrap_taken got %b want 0", o_taken); end
    endtask

    task automatic test_flags_jz();
        step(1'b1, NEXT, 12'h000, 1'b1, 16'h0000, 1'b0, 1'b0);
        total++; if (o_flags !== 3'b001) begin bad++; $display("FAIL flags_zero got %b want 001", o_flags); end
        step(1'b1, JZE, 12'h100, 1'b0, 16'h0000, 1'b0, 1'b0);
        total++; if (o_pc !== 12'h100 || o_taken !== 1'b1) begin bad++; $display("FAIL jze_taken got pc=%h tk=%b want pc=100 tk=1", o_pc, o_taken); end
        step(1'b1, NEXT, 12'h000, 1'b1, 16'h8000, 1'b0, 1'b0);
        total++; if (o_flags !== 3'b010) begin bad++; $display("FAIL flags_neg got %b want 010", o_flags); end
        step(1'b1, JZE, 12'h1F0, 1'b0, 16'h0000, 1'b0, 1'b0);
        total++; if (o_pc !== 12'h102 || o_taken !== 1'b0) begin bad++; $display("FAIL jze_not got pc=%h tk=%b want pc=102 tk=0", o_pc, o_taken); end
        step(1'b1, JNE, 12'h180, 1'b0, 16'h0000, 1'b0, 1'b0);
        total++; if (o_pc !== 12'h180 || o_taken !== 1'b1) begin bad++; $display("FAIL jne_taken got pc=%h tk=%b want pc=180 tk=1", o_pc, o_taken); end
    endtask

    task automatic test_carry();
        step(1'b1, JCY, 12'h040, 1'b1, 16'h0001, 1'b1, 1'b0);
        total++; if (o_pc !== 12'h181 || o_taken !== 1'b0) begin bad++; $display("FAIL jcy_oldflag got pc=%h tk=%b want pc=181 tk=0", o_pc, o_taken); end
        total++; if (o_flags !== 3'b100) begin bad++; $display("FAIL flags_carry got %b want 100", o_flags); end
        step(1'b1, JCY, 12'h040, 1'b0, 16'h0000, 1'b0, 1'b0);
        total++; if (o_pc !== 12'h040 || o_taken !== 1'b1) begin bad++; $display("FAIL jcy_taken got pc=%h tk=%b want pc=040 tk=1", o_pc, o_taken); end
        step(1'b1, JNC, 12'h050, 1'b0, 16'h0000, 1'b0, 1'b0);
        total++; if (o_pc !== 12'h041 || o_taken !== 1'b0) begin bad++; $display("FAIL jnc_not got pc=%h tk=%b want pc=041 tk=0", o_pc, o_taken); end
    endtask

    task automatic test_call_ret();
        step(1'b1, JMP, 12'h010, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, CALL, 12'h200, 1'b0, 16'h0000, 1'b0, 1'b0);
        total++; if (o_pc !== 12'h200 || o_sp !== 3'd1) begin bad++; $display("FAIL call1 got pc=%h sp=%0d want pc=200 sp=1", o_pc, o_sp); end
        step(1'b1, CALL, 12'h300, 1'b0, 16'h0000, 1'b0, 1'b0);
        total++; if (o_pc !== 12'h300 || o_sp !== 3'd2) begin bad++; $display("FAIL call2 got pc=%h sp=%0d want pc=300 sp=2", o_pc, o_sp); end
        step(1'b1, RET, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0);
        total++; if (o_pc !== 12'h201 || o_sp !== 3'd1 || o_taken !== 1'b1) begin bad++; $display("FAIL ret1 got pc=%h sp=%0d tk=%b want pc=201 sp=1 tk=1", o_pc, o_sp, o_taken); end
        step(1'b1, RET, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0);
        total++; if (o_pc !== 12'h011 || o_sp !== 3'd0) begin bad++; $display("FAIL ret2 got pc=%h sp=%0d want pc=011 sp=0", o_pc, o_sp); end
    endtask

    task automatic test_overflow();
        step(1'b1, CALL, 12'h400, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, CALL, 12'h500, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, CALL, 12'h600, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, CALL, 12'h700, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, CALL, 12'h800, 1'b0, 16'h0000, 1'b0, 1'b0);
        total++; if (o_pc !== 12'h701 || o_sp !== 3'd4 || o_stack_err !== 1'b1 || o_taken !== 1'b0) begin
            bad++; $display("FAIL call_full got pc=%h sp=%0d err=%b tk=%b want pc=701 sp=4 err=1 tk=0", o_pc, o_sp, o_stack_err, o_taken);
        end
        step(1'b1, NEXT, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b1);
        total++; if (o_stack_err !== 1'b0) begin bad++; $display("FAIL err_clear got %b want 0", o_stack_err); end
        step(1'b1, CALL, 12'h800, 1'b0, 16'h0000, 1'b0, 1'b1);
        total++; if (o_stack_err !== 1'b1) begin bad++; $display("FAIL err_set_wins got %b want 1", o_stack_err); end
    endtask

    task automatic test_en_low();
        step(1'b0, JMP, 12'h123, 1'b1, 16'hFFFF, 1'b1, 1'b1);
        total++; if (o_pc !== 12'h703 || o_taken !== 1'b0) begin bad++; $display("FAIL en_low_pc got pc=%h tk=%b want pc=703 tk=0", o_pc, o_taken); end
        total++; if (o_flags !== 3'b110 || o_stack_err !== 1'b0) begin bad++; $display("FAIL en_low_side got fl=%b err=%b want fl=110 err=0", o_flags, o_stack_err); end
    endtask

    task automatic test_ret_empty();
        apply_reset();
        step(1'b1, RET, 12'h055, 1'b0, 16'h0000, 1'b0, 1'b0);
        total++; if (o_pc !== 12'h001 || o_stack_err !== 1'b1 || o_sp !== 3'd0) begin
            bad++; $display("FAIL ret_empty got pc=%h err=%b sp=%0d want pc=001 err=1 sp=0", o_pc, o_stack_err, o_sp);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, CALL, 12'h250, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, CALL, 12'h260, 1'b0, 16'h0000, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (o_pc !== 12'h000 || o_sp !== 3'd0 || o_taken !== 1'b0 || o_stack_err !== 1'b0) begin
            bad++; $display("FAIL async_rst got pc=%h sp=%0d tk=%b err=%b want all 0", o_pc, o_sp, o_taken, o_stack_err);
        end
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, NEXT, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0);
        total++; if (o_pc !== 12'h001) begin bad++; $display("FAIL post_rst_next got %h want 001", o_pc); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 12'($urandom),
                 1'($urandom), (($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom)),
                 1'($urandom), ($urandom_range(0, 7) == 0));
        end
        total++; if (o_sp !== SP_W'(m_sp)) begin bad++; $display("FAIL b2b_sp got %0d want %0d", o_sp, m_sp); end
    endtask

    initial begin
        test_reset();
        test_next_wrap();
        test_flags_jz();
        test_carry();
        test_call_ret();
        test_overflow();
        test_en_low();
        test_ret_empty();
        test_async_reset();
        test_back_to_back();
        @(negedge clk);
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, width of the accumulator W sampled for flags.
REQ-002 Parameter ADDR_W, default 12, program-counter and jump-target width.
REQ-003 Parameter STACK_DEPTH, default 4, return-stack entries (>=1).
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 RST_N  in  1  asynchronous, active-low reset.
REQ-006 EN  in  1  instruction step; PC, stack and TAKEN update only when EN=1.
REQ-007 OPCODE  in  3  sequencing operation (encoding in REQ-016).
REQ-008 TARGET  in  ADDR_W  jump/call destination.
REQ-009 FLAG_LD  in  1  latch flags from W and CY this edge; independent of EN.
REQ-010 W  in  DATA_W  accumulator value for Z/N flag capture.
REQ-011 CY  in  1  ALU carry for C flag capture.
REQ-012 ERR_CLR  in  1  clears STACK_ERR.
REQ-013 PC  out  ADDR_W  registered program counter.
REQ-014 TAKEN  out  1  registered; 1 for one cycle after a taken jump, CALL or RET.
REQ-015 FLAGS  out  3  registered {C,N,Z}; SP  out  $clog2(STACK_DEPTH+1)  stack occupancy; STACK_ERR  out  1  sticky stack fault.

Function
REQ-016 OPCODE encoding: 000 NEXT, 001 JMP, 010 JZE (Z), 011 JNE (N, sign), 100 JCY (C), 101 JNC (!C), 110 CALL, 111 RET.
REQ-017 FLAG_LD=1: Z<=(W==0), N<=W[DATA_W-1], C<=CY at the edge; FLAG_LD=0 holds flags.
REQ-018 Conditions evaluate pre-edge flag values; FLAG_LD and a conditional jump in the same cycle -> jump uses old flags, new flags visible next cycle.
REQ-019 EN=1, jump taken (JMP always; JZE/JNE/JCY/JNC when condition true): PC<=TARGET, TAKEN<=1.
REQ-020 EN=1, NEXT or condition false: PC<=PC+1 modulo 2^ADDR_W (all-ones wraps to 0), TAKEN<=0.
REQ-021 CALL with SP<STACK_DEPTH: push (PC+1) mod 2^ADDR_W, SP<=SP+1, PC<=TARGET, TAKEN<=1.
REQ-022 RET with SP>0: PC<=top entry, SP<=SP-1, TAKEN<=1.
REQ-023 CALL with SP=STACK_DEPTH (full): no push, SP unchanged, PC<=PC+1, TAKEN<=0, STACK_ERR<=1.
REQ-024 RET with SP=0 (empty): no pop, PC<=PC+1, TAKEN<=0, STACK_ERR<=1.
REQ-025 EN=0: PC, SP, stack, TAKEN<=0; flags still follow FLAG_LD; ERR_CLR still acts.
REQ-026 STACK_ERR sticky; ERR_CLR=1 clears it; new fault in same cycle as ERR_CLR -> STACK_ERR=1 (set wins).
REQ-027 Latency: every output reflects the operation one edge after sampling; no combinational input-to-output path.

Reset
REQ-028 RST_N=0 asynchronously forces PC=0, TAKEN=0, FLAGS=000, SP=0, STACK_ERR=0, all stack entries 0.
REQ-029 Reset asserted mid-operation discards the in-flight step; first step after release executes from PC=0.
REQ-030 Release is synchronised externally; block assumes RST_N deasserts cleanly w.r.t. CLK.

Structure
REQ-031 Opcode localparams (OP_NEXT..OP_RET) and flag bit indices (FLAG_Z=0, FLAG_N=1, FLAG_C=2) live in shared package ev22_pkg.
REQ-032 Return stack is a sub-module ret_stack (parameters ADDR_W, STACK_DEPTH; push/pop/full/empty/top/count).
REQ-033 pc_sequencer holds flag register, condition decode, PC register and fault logic.

Verification
REQ-034 Reset, then 4096 steps of NEXT (ADDR_W=12) -> PC runs 0..4095 and wraps to 0, TAKEN=0 throughout.
REQ-035 FLAG_LD with W=0 -> FLAGS=001; JZE TARGET=0x100 -> PC=0x100, TAKEN=1; W=0x8000, FLAG_LD, JZE -> not taken; JNE -> taken.
REQ-036 CY=1 with FLAG_LD and JCY same cycle (old C=0) -> not taken; next-cycle JCY -> taken; JNC then -> not taken.
REQ-037 PC=0x010: CALL 0x200, CALL 0x300, RET, RET -> PC 0x200, 0x300, 0x201, 0x011; SP 1,2,1,0.
REQ-038 5 CALLs with STACK_DEPTH=4 -> 5th: PC+1, SP=4, STACK_ERR=1; RET on empty after reset -> STACK_ERR=1; ERR_CLR with simultaneous fault -> stays 1.
REQ-039 RST_N pulsed low between edges mid-CALL sequence -> outputs zero immediately, SP=0, first post-reset NEXT gives PC=1.
